// File: rtl/ledr_alarm_sequencer.sv
// Sole Avalon-MM write master for the LEDR PIO: host writes pre-empted by an alarm light show.
// Define ALARM_HOST_OVERLAY_EN to OR the host LED value into every alarm frame.
module ledr_alarm_sequencer #(
  parameter int STEP_CYCLES = 25000000,
  parameter int LED_W       = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             host_req,
  input  logic [LED_W-1:0] host_data,
  input  logic             alarm_active,
  input  logic [1:0]       alarm_mode,
  input  logic [LED_W-1:0] alarm_pattern,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  output logic             alarm_busy
);

  localparam int CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
`ifdef ALARM_HOST_OVERLAY_EN
  localparam bit OVERLAY = 1'b1;
`else
  localparam bit OVERLAY = 1'b0;
`endif

  typedef enum logic [1:0] {S_HOST, S_ALARM, S_RESTORE} state_t;

  localparam logic [1:0] M_BLINK  = 2'd0;
  localparam logic [1:0] M_CHASE  = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_STATIC = 2'd3;

  state_t           state, state_d;
  logic [LED_W-1:0] host_value, host_next;
  logic [CNT_W-1:0] step_cnt, cnt_d;
  logic [LED_W-1:0] frame, frame_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_up, dir_d;
  logic             pend_host, pend_d;
  logic             wr;
  logic [LED_W-1:0] wdata;

  function automatic logic [LED_W-1:0] first_frame(input logic [1:0] m,
                                                   input logic [LED_W-1:0] p);
    first_frame = (m == M_CHASE || m == M_BOUNCE) ? LED_W'(1) : p;
  endfunction

  assign host_next = host_req ? host_data : host_value;

  always_comb begin
    state_d = state;
    cnt_d   = step_cnt;
    frame_d = frame;
    mode_d  = mode_q;
    dir_d   = dir_up;
    pend_d  = 1'b0;
    wr      = 1'b0;
    wdata   = host_next;
    unique case (state)
      S_HOST, S_RESTORE: begin
        if (alarm_active) begin
          state_d = S_ALARM;
          mode_d  = alarm_mode;
          cnt_d   = '0;
          frame_d = first_frame(alarm_mode, alarm_pattern);
          dir_d   = 1'b1;
          wr      = 1'b1;
          wdata   = frame_d | (OVERLAY ? host_next : '0);
        end else if (state == S_RESTORE) begin
          // A host strobe during restore is replayed once back in S_HOST.
          state_d = S_HOST;
          pend_d  = host_req;
        end else if (host_req || pend_host) begin
          wr = 1'b1;
        end
      end
      S_ALARM: begin
        if (!alarm_active) begin
          state_d = S_RESTORE;
          wr      = 1'b1;
        end else begin
          cnt_d = (step_cnt == CNT_LAST) ? '0 : step_cnt + CNT_W'(1);
          if (step_cnt == CNT_LAST) begin
            mode_d = alarm_mode;
            wr     = 1'b1;
            if (alarm_mode != mode_q) begin
              frame_d = first_frame(alarm_mode, alarm_pattern);
              dir_d   = 1'b1;
            end else begin
              unique case (mode_q)
                M_BLINK:  frame_d = (frame == '0) ? alarm_pattern : '0;
                M_CHASE:  frame_d = {frame[LED_W-2:0], frame[LED_W-1]};
                M_BOUNCE: begin
                  if (dir_up && frame[LED_W-1]) begin
                    frame_d = frame >> 1;
                    dir_d   = 1'b0;
                  end else if (!dir_up && frame[0]) begin
                    frame_d = frame << 1;
                    dir_d   = 1'b1;
                  end else begin
                    frame_d = dir_up ? (frame << 1) : (frame >> 1);
                  end
                end
                M_STATIC: begin
                  wr      = (alarm_pattern != frame);
                  frame_d = alarm_pattern;
                end
              endcase
            end
          end
          if (OVERLAY && host_req) wr = 1'b1;
          wdata = frame_d | (OVERLAY ? host_next : '0);
        end
      end
      default: state_d = S_HOST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_HOST;
      host_value     <= '0;
      step_cnt       <= '0;
      frame          <= '0;
      mode_q         <= M_BLINK;
      dir_up         <= 1'b1;
      pend_host      <= 1'b0;
      pio_address    <= 2'd0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= 32'd0;
      alarm_busy     <= 1'b0;
    end else begin
      state          <= state_d;
      host_value     <= host_next;
      step_cnt       <= cnt_d;
      frame          <= frame_d;
      mode_q         <= mode_d;
      dir_up         <= dir_d;
      pend_host      <= pend_d;
      pio_address    <= 2'd0;
      pio_chipselect <= wr;
      pio_write_n    <= ~wr;
      if (wr) pio_writedata <= {{(32-LED_W){1'b0}}, wdata};
      alarm_busy     <= (state_d != S_HOST);
    end
  end

endmodule

// File: tb/tb_ledr_alarm_sequencer.sv
// Self-checking bench for ledr_alarm_sequencer: captured PIO writes are compared
// against a write list derived from cycle arithmetic and closed-form pattern formulas.
module tb_ledr_alarm_sequencer;
  localparam int STEP = 4;
  localparam int LW   = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_req;
  logic [LW-1:0] host_data;
  logic          alarm_active;
  logic [1:0]    alarm_mode;
  logic [LW-1:0] alarm_pattern;
  logic [1:0]    pio_address;
  logic          pio_chipselect;
  logic          pio_write_n;
  logic [31:0]   pio_writedata;
  logic          alarm_busy;

  ledr_alarm_sequencer #(.STEP_CYCLES(STEP), .LED_W(LW)) dut (
    .clk(clk), .reset(reset), .host_req(host_req), .host_data(host_data),
    .alarm_active(alarm_active), .alarm_mode(alarm_mode), .alarm_pattern(alarm_pattern),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
    .pio_writedata(pio_writedata), .alarm_busy(alarm_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [LW-1:0] model_host;

  int          wr_cyc[$];
  logic [31:0] wr_val[$];
  int          exp_cyc[$];
  logic [31:0] exp_val[$];

  // A write is recorded against the edge number that launched it.
  always @(negedge clk)
    if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
      wr_cyc.push_back(cyc);
      wr_val.push_back(pio_writedata);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    wr_cyc.delete(); wr_val.delete(); exp_cyc.delete(); exp_val.delete();
  endtask

  // Frame k of an uninterrupted alarm, from the pattern rules alone.
  function automatic logic [31:0] model_frame(input int mode, input int k, input logic [LW-1:0] p);
    int q, pos;
    case (mode)
      0: return (k % 2 == 0) ? {22'd0, p} : 32'd0;
      1: return 32'd1 << (k % LW);
      2: begin
        q   = k % (2 * (LW - 1));
        pos = (q < LW) ? q : 2 * (LW - 1) - q;
        return 32'd1 << pos;
      end
      default: return (k == 0) ? {22'd0, p} : 32'd0;
    endcase
  endfunction

  task automatic test_reset();
    logic [LW-1:0] p;
    int t0;
    reset = 1; host_req = 0; host_data = 0; alarm_active = 0; alarm_mode = 0; alarm_pattern = 0;
    repeat (3) tick();
    checks += 5;
    if (pio_chipselect !== 1'b0) begin errors++; $display("[TB] FAIL reset chipselect: got %b want 0", pio_chipselect); end
    if (pio_write_n !== 1'b1) begin errors++; $display("[TB] FAIL reset write_n: got %b want 1", pio_write_n); end
    if (pio_address !== 2'd0) begin errors++; $display("[TB] FAIL reset address: got %0d want 0", pio_address); end
    if (pio_writedata !== 32'd0) begin errors++; $display("[TB] FAIL reset writedata: got %h want 0", pio_writedata); end
    if (alarm_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b want 0", alarm_busy); end
    reset = 0; model_host = 0;
    tick();
    clear_queues();
    // A short static alarm after reset must restore the cleared host value.
    p = LW'($urandom_range(1, 1023));
    alarm_mode = 3; alarm_pattern = p; alarm_active = 1; t0 = cyc + 1;
    tick();
    alarm_active = 0;
    repeat (4) tick();
    exp_cyc = '{t0, t0 + 1};
    exp_val = '{{22'd0, p}, 32'd0};
    checks++;
    if (wr_val.size() != exp_val.size()) begin errors++; $display("[TB] FAIL reset restore count: got %0d want %0d", wr_val.size(), exp_val.size()); end
    for (int i = 0; i < exp_val.size() && i < wr_val.size(); i++) begin
      checks++;
      if (wr_val[i] !== exp_val[i] || wr_cyc[i] !== exp_cyc[i]) begin
        errors++; $display("[TB] FAIL reset restore #%0d: got %h@%0d want %h@%0d", i, wr_val[i], wr_cyc[i], exp_val[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_host_write();
    int e;
    for (int n = 0; n < 6; n++) begin
      clear_queues();
      host_data = (n == 0) ? 10'h2A5 : LW'($urandom);
      host_req = 1; model_host = host_data; e = cyc + 1;
      tick();
      host_req = 0;
      repeat (3) tick();
      checks += 2;
      if (wr_val.size() != 1 || wr_cyc[0] !== e || wr_val[0] !== {22'd0, model_host}) begin
        errors++;
        $display("[TB] FAIL host write #%0d: got %0d writes first %h@%0d want %h@%0d", n, wr_val.size(),
                 (wr_val.size() > 0) ? wr_val[0] : 32'hX, (wr_cyc.size() > 0) ? wr_cyc[0] : -1, {22'd0, model_host}, e);
      end
      if (alarm_busy !== 1'b0) begin errors++; $display("[TB] FAIL host busy: got %b want 0", alarm_busy); end
    end
  endtask

  task automatic test_alarm_mode(input int mode);
    logic [LW-1:0] p;
    int t0, len, host_at, d;
    clear_queues();
    p = LW'($urandom_range(1, 1023));
    len = STEP * ((mode == 2) ? $urandom_range(20, 22) : $urandom_range(11, 13)) + $urandom_range(0, STEP - 1);
    host_at = $urandom_range(3, len - 3);
    alarm_mode = 2'(mode); alarm_pattern = p; alarm_active = 1; t0 = cyc + 1;
    for (int i = 0; i < len; i++) begin
      host_req = (i == host_at);
      if (i == host_at) begin host_data = LW'($urandom); model_host = host_data; end
      tick();
      if (i == STEP + 1) begin
        checks++;
        if (alarm_busy !== 1'b1) begin errors++; $display("[TB] FAIL mode%0d busy: got %b want 1", mode, alarm_busy); end
      end
    end
    host_req = 0; alarm_active = 0; d = cyc + 1;
    tick();
    checks++;
    if (alarm_busy !== 1'b1) begin errors++; $display("[TB] FAIL mode%0d restore busy: got %b want 1", mode, alarm_busy); end
    tick();
    checks++;
    if (alarm_busy !== 1'b0) begin errors++; $display("[TB] FAIL mode%0d idle busy: got %b want 0", mode, alarm_busy); end
    repeat (3) tick();
    for (int k = 0; t0 + STEP * k < d; k++)
      if (mode != 3 || k == 0) begin exp_cyc.push_back(t0 + STEP * k); exp_val.push_back(model_frame(mode, k, p)); end
    exp_cyc.push_back(d); exp_val.push_back({22'd0, model_host});
    checks++;
    if (wr_val.size() != exp_val.size()) begin errors++; $display("[TB] FAIL mode%0d write count: got %0d want %0d", mode, wr_val.size(), exp_val.size()); end
    for (int i = 0; i < exp_val.size() && i < wr_val.size(); i++) begin
      checks++;
      if (wr_val[i] !== exp_val[i] || wr_cyc[i] !== exp_cyc[i]) begin
        errors++; $display("[TB] FAIL mode%0d write #%0d: got %h@%0d want %h@%0d", mode, i, wr_val[i], wr_cyc[i], exp_val[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_mode_change();
    logic [LW-1:0] p, p2;
    int t0;
    clear_queues();
    p = LW'($urandom_range(1, 1023));
    p2 = p ^ LW'($urandom_range(1, 1023));
    t0 = cyc + 1;
    for (int i = 0; i < 23; i++) begin
      alarm_active  = (i < 18);
      alarm_mode    = (i < 6) ? 2'd1 : 2'd3;
      alarm_pattern = (i < 13) ? p : p2;
      tick();
    end
    exp_cyc = '{t0, t0 + 4, t0 + 8, t0 + 16, t0 + 18};
    exp_val = '{32'h1, 32'h2, {22'd0, p}, {22'd0, p2}, {22'd0, model_host}};
    checks++;
    if (wr_val.size() != exp_val.size()) begin errors++; $display("[TB] FAIL mode change count: got %0d want %0d", wr_val.size(), exp_val.size()); end
    for (int i = 0; i < exp_val.size() && i < wr_val.size(); i++) begin
      checks++;
      if (wr_val[i] !== exp_val[i] || wr_cyc[i] !== exp_cyc[i]) begin
        errors++; $display("[TB] FAIL mode change #%0d: got %h@%0d want %h@%0d", i, wr_val[i], wr_cyc[i], exp_val[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    clear_queues();
    alarm_mode = 1; host_data = 10'h155; model_host = 10'h155; t0 = cyc + 1;
    // Host strobe coincides with alarm rise; alarm drops for one edge then returns during restore.
    for (int i = 0; i < 17; i++) begin
      host_req = (i == 0);
      alarm_active = (i != 6 && i < 12);
      tick();
    end
    exp_cyc = '{t0, t0 + 4, t0 + 6, t0 + 7, t0 + 11, t0 + 12};
    exp_val = '{32'h1, 32'h2, 32'h155, 32'h1, 32'h2, 32'h155};
    checks++;
    if (wr_val.size() != exp_val.size()) begin errors++; $display("[TB] FAIL back to back count: got %0d want %0d", wr_val.size(), exp_val.size()); end
    for (int i = 0; i < exp_val.size() && i < wr_val.size(); i++) begin
      checks++;
      if (wr_val[i] !== exp_val[i] || wr_cyc[i] !== exp_cyc[i]) begin
        errors++; $display("[TB] FAIL back to back #%0d: got %h@%0d want %h@%0d", i, wr_val[i], wr_cyc[i], exp_val[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_restore_pending();
    logic [LW-1:0] p, old_host, v;
    int t0;
    clear_queues();
    p = LW'($urandom_range(1, 1023));
    v = ~model_host;
    old_host = model_host;
    alarm_mode = 3; alarm_pattern = p; t0 = cyc + 1;
    for (int i = 0; i < 9; i++) begin
      alarm_active = (i < 3);
      host_req = (i == 4);
      host_data = v;
      tick();
    end
    model_host = v;
    exp_cyc = '{t0, t0 + 3, t0 + 5};
    exp_val = '{{22'd0, p}, {22'd0, old_host}, {22'd0, v}};
    checks++;
    if (wr_val.size() != exp_val.size()) begin errors++; $display("[TB] FAIL restore pending count: got %0d want %0d", wr_val.size(), exp_val.size()); end
    for (int i = 0; i < exp_val.size() && i < wr_val.size(); i++) begin
      checks++;
      if (wr_val[i] !== exp_val[i] || wr_cyc[i] !== exp_cyc[i]) begin
        errors++; $display("[TB] FAIL restore pending #%0d: got %h@%0d want %h@%0d", i, wr_val[i], wr_cyc[i], exp_val[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] v;
    alarm_mode = 2; alarm_active = 1; host_req = 0;
    tick();
    checks++;
    if (pio_chipselect !== 1'b1 || pio_writedata !== 32'h1) begin
      errors++; $display("[TB] FAIL mid strobe: got cs=%b data=%h want cs=1 data=00000001", pio_chipselect, pio_writedata);
    end
    reset = 1; alarm_active = 0;
    tick();
    checks += 4;
    if (pio_chipselect !== 1'b0) begin errors++; $display("[TB] FAIL mid reset chipselect: got %b want 0", pio_chipselect); end
    if (pio_write_n !== 1'b1) begin errors++; $display("[TB] FAIL mid reset write_n: got %b want 1", pio_write_n); end
    if (pio_writedata !== 32'd0) begin errors++; $display("[TB] FAIL mid reset writedata: got %h want 0", pio_writedata); end
    if (alarm_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid reset busy: got %b want 0", alarm_busy); end
    reset = 0; model_host = 0;
    tick();
    v = LW'($urandom_range(1, 1023));
    host_req = 1; host_data = v; model_host = v;
    tick();
    host_req = 0;
    checks++;
    if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b0 || pio_writedata !== {22'd0, v} || alarm_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL post reset host: got cs=%b wn=%b data=%h busy=%b want cs=1 wn=0 data=%h busy=0",
                         pio_chipselect, pio_write_n, pio_writedata, alarm_busy, {22'd0, v});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_alarm_mode(0);
    test_alarm_mode(1);
    test_alarm_mode(2);
    test_alarm_mode(3);
    test_mode_change();
    test_back_to_back();
    test_restore_pending();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
